led_share_arbiter: RTL and testbench

//  Shares the single open-drain, active-low board LED among N_REQ requesters
//  (status, error, heartbeat, ...). Each requester asks for the LED with its own PWM duty.

---
 rtl/led_arb_pkg.sv | 20 ++
 rtl/led_pwm_core.sv | 36 +++
 rtl/led_share_arbiter.sv | 115 +++++++++++
 tb/tb_led_share_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED share arbiter: FSM state enum,
// round-robin next-owner search and default timing constants.
package led_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_SERVE, ST_GAP} arb_state_t;

  localparam int DEF_PWM_BITS    = 8;
  localparam int DEF_SLOT_CYCLES = 6_250_000;
  localparam int MAX_REQ         = 8;

  // First set request after ptr, wrapping through ptr itself; returns ptr if none.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr, input int n);
    logic [2:0] idx;
    rr_next = ptr;
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i <= n && req[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/led_pwm_core.sv
// PWM engine for the shared LED: free-running counter, duty register reloaded
// only on wrap, registered active-low LED output and a wrap pulse.
module led_pwm_core
  import led_arb_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led,
  output logic                wrap
);
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  assign wrap = en && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      led     <= 1'b1;
    end else if (!en) begin
      // Parked: dark, counter at phase 0, duty tracks the next owner.
      pwm_cnt <= '0;
      duty_q  <= duty;
      led     <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= ~(pwm_cnt < duty_q);
      if (wrap) duty_q <= duty;
    end
  end
endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin time-slot sharing of one active-low LED with per-requester PWM.
// Optional LED_ARB_PREEMPT_EN: req[0] takes over at the next PWM wrap, no gap.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*PWM_BITS-1:0] duty,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      led
);
  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] GAP_LAST  = SW'(2**PWM_BITS - 1);

  arb_state_t state;
  logic [IW-1:0] rr_ptr, own, pick, sel;
  logic [SW-1:0] slot_cnt;
  logic          pwm_en, wrap, preempt, others;
  logic [N_REQ-1:0][PWM_BITS-1:0] duty_v;
  logic [PWM_BITS-1:0] duty_sel;

  assign duty_v = duty;
  assign pick   = IW'(rr_next(MAX_REQ'(req), 3'(rr_ptr), N_REQ));
  assign others = |(req & ~grant);
  assign pwm_en = (state == ST_SERVE);

`ifdef LED_ARB_PREEMPT_EN
  assign preempt = (state == ST_SERVE) && wrap && req[0] && (own != '0);
`else
  assign preempt = 1'b0;
`endif

  // Duty feeding the PWM reload must belong to whoever owns the next period.
  assign sel      = (state == ST_ARB) ? pick : (preempt ? '0 : own);
  assign duty_sel = duty_v[sel];

  led_pwm_core #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pwm_en),
    .duty (duty_sel),
    .led  (led),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      rr_ptr   <= IW'(N_REQ - 1);
      own      <= '0;
      slot_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          slot_cnt <= '0;
          if (|req) begin
            state <= ST_ARB;
            busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          slot_cnt <= '0;
          if (|req) begin
            state  <= ST_SERVE;
            grant  <= N_REQ'(1) << pick;
            own    <= pick;
            rr_ptr <= pick;
          end else begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (slot_cnt != SLOT_LAST) slot_cnt <= slot_cnt + 1'b1;
          if (preempt) begin
            // rr_ptr deliberately kept so rotation resumes after the urgent slot.
            grant    <= N_REQ'(1);
            own      <= '0;
            slot_cnt <= '0;
          end else if (wrap && (slot_cnt == SLOT_LAST || !req[own])) begin
            slot_cnt <= '0;
            if (req != grant) begin
              grant <= '0;
              if (others) state <= ST_GAP;
              else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        ST_GAP: begin
          // slot_cnt doubles as the gap timer: one full dark PWM period.
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == GAP_LAST) begin
            state    <= ST_ARB;
            slot_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter (N_REQ=4, PWM_BITS=4, SLOT_CYCLES=32).
module tb_led_share_arbiter;
  localparam int N  = 4;
  localparam int PB = 4;
  localparam int SC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [15:0] duty = 16'h4444;
  logic [3:0]  grant;
  logic        busy, led;
  int errs = 0;
  int checks = 0;

  led_share_arbiter #(.N_REQ(N), .PWM_BITS(PB), .SLOT_CYCLES(SC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .duty (duty),
    .grant(grant),
    .busy (busy),
    .led  (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected active-low LED for PWM phase c with duty d (16-step period).
  function automatic logic led_exp(input int c, input int d);
    return ((c % 16) < d) ? 1'b0 : 1'b1;
  endfunction

  task automatic do_reset(input logic [3:0] r, input logic [15:0] d);
    rst_n = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_led", 32'(led), 1);
    duty  = d;
    req   = r;
    rst_n = 1'b1;
  endtask

  initial begin
    int dd[4];
    int g, gg, s;
    // 1: reset held with all requests set
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_grant", 32'(grant), 0);
      chk("t1_busy", 32'(busy), 0);
      chk("t1_led", 32'(led), 1);
    end

    // 2: single requester, duty 4
    duty  = 16'h0004;
    req   = 4'b0001;
    rst_n = 1'b1;
    step();
    chk("t2_arb_grant", 32'(grant), 0);
    chk("t2_arb_busy", 32'(busy), 1);
    step();
    chk("t2_grant", 32'(grant), 4'b0001);
    for (int j = 1; j <= 40; j++) begin
      step();
      chk("t2_led", 32'(led), 32'(led_exp(j - 1, 4)));
      chk("t2_hold", 32'(grant), 4'b0001);
    end

    // 3: all request, full rotation with gaps; duties 0,5,9,15
    dd = '{0, 5, 9, 15};
    do_reset(4'b1111, {4'd15, 4'd9, 4'd5, 4'd0});
    for (int e = 1; e <= 200; e++) begin
      step();
      if (e < 2) begin
        chk("t3_grant", 32'(grant), 0);
        chk("t3_led", 32'(led), 1);
      end else begin
        g  = e - 2;
        gg = g % 49;
        s  = g / 49;
        chk("t3_grant", 32'(grant), (gg < 32) ? (1 << (s % 4)) : 0);
        chk("t3_led", 32'(led),
            (gg == 0 || gg >= 32) ? 1 : 32'(led_exp(gg - 1, dd[s % 4])));
      end
    end

    // 4: owner 2 drops at pwm_cnt=5, period completes, gap, then owner 3
    do_reset(4'b1100, {4'd3, 4'd8, 4'd0, 4'd0});
    step();
    step();
    chk("t4_grant", 32'(grant), 4'b0100);
    for (int j = 1; j <= 34; j++) begin
      step();
      chk("t4_grant", 32'(grant), (j < 16) ? 4'b0100 : ((j < 33) ? 4'b0000 : 4'b1000));
      chk("t4_led", 32'(led), (j <= 8) ? 0 : ((j <= 33) ? 1 : 32'(led_exp(0, 3))));
      if (j == 5) req = 4'b1000;
    end

    // 5: lone owner re-granted without gap; duty change applies at wrap
    do_reset(4'b0100, {4'd0, 4'd8, 4'd0, 4'd0});
    step();
    step();
    for (int j = 1; j <= 100; j++) begin
      step();
      chk("t5_grant", 32'(grant), 4'b0100);
      chk("t5_busy", 32'(busy), 1);
      chk("t5_led", 32'(led), 32'(led_exp(j - 1, (j <= 32) ? 8 : 12)));
      if (j == 20) duty = {4'd0, 4'd12, 4'd0, 4'd0};
    end

`ifdef LED_ARB_PREEMPT_EN
    // 6: urgent req[0] takes over owner 3 at wrap, rotation then goes to 1
    do_reset(4'b1000, {4'd6, 4'd0, 4'd0, 4'd10});
    step();
    step();
    chk("t6_grant", 32'(grant), 4'b1000);
    for (int j = 1; j <= 50; j++) begin
      step();
      chk("t6_grant", 32'(grant),
          (j < 16) ? 4'b1000 : ((j < 32) ? 4'b0001 : ((j < 49) ? 4'b0000 : 4'b0010)));
      chk("t6_led", 32'(led),
          (j <= 16) ? 32'(led_exp(j - 1, 6)) :
          ((j <= 32) ? 32'(led_exp(j - 1, 10)) : 1));
      if (j == 3)  req = 4'b1001;
      if (j == 20) req = 4'b1010;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
